// File: rtl/rmt_xbar_pkg.sv
// Shared definitions for the RMT operand crossbar: opcodes, operand-source
// encoding and action-word field positions.
package rmt_xbar_pkg;

  localparam int OP_W = 8;

  localparam logic [7:0] OP_01 = 8'h01;
  localparam logic [7:0] OP_02 = 8'h02;
  localparam logic [7:0] OP_03 = 8'h03;
  localparam logic [7:0] OP_04 = 8'h04;
  localparam logic [7:0] OP_05 = 8'h05;
  localparam logic [7:0] OP_06 = 8'h06;
  localparam logic [7:0] OP_07 = 8'h07;
  localparam logic [7:0] OP_08 = 8'h08;
  localparam logic [7:0] OP_09 = 8'h09;
  localparam logic [7:0] OP_0A = 8'h0A;
  localparam logic [7:0] OP_0B = 8'h0B;
  localparam logic [7:0] OP_0C = 8'h0C;
  localparam logic [7:0] OP_0E = 8'h0E;
  localparam logic [7:0] OP_10 = 8'h10;
  localparam logic [7:0] OP_11 = 8'h11;
  localparam logic [7:0] OP_12 = 8'h12;
  localparam logic [7:0] OP_13 = 8'h13;
  localparam logic [7:0] OP_14 = 8'h14;
  localparam logic [7:0] OP_17 = 8'h17;
  localparam logic [7:0] OP_18 = 8'h18;
  localparam logic [7:0] OP_1B = 8'h1B;
  localparam logic [7:0] OP_1C = 8'h1C;
  localparam logic [7:0] OP_1D = 8'h1D;

  typedef enum logic [2:0] {
    SRC_PHV0, SRC_PHV1, SRC_PHV2, SRC_IMM, SRC_CTL, SRC_ZERO, SRC_SELF
  } opnd_src_e;

  function automatic int op_msb(input int act_len);
    return act_len - 1;
  endfunction

  // Source index k (0..2) sits right below the opcode, fields packed back to back.
  function automatic int src_msb(input int act_len, input int idx_w, input int k);
    return act_len - 1 - OP_W - k * idx_w;
  endfunction

  // The control field starts after s0/s1 and therefore shares its top bits with s2.
  function automatic int ctl_msb(input int act_len, input int idx_w);
    return act_len - 1 - OP_W - 2 * idx_w;
  endfunction

endpackage

// File: rtl/rmt_operand_xbar_if.sv
// Beat-level bus of the operand crossbar: input PHV/action handshake and the
// aligned operand/metadata/action output handshake.
interface rmt_operand_xbar_if #(
  parameter int NUM_CONT = 64,
  parameter int CONT_W   = 32,
  parameter int ACT_LEN  = 64,
  parameter int META_W   = 256
) ();
  localparam int PHV_LEN = NUM_CONT * CONT_W + META_W;

  logic                          in_valid;
  logic                          in_ready;
  logic [PHV_LEN-1:0]            phv_in;
  logic [(NUM_CONT+1)*ACT_LEN-1:0] action_in;
  logic                          out_valid;
  logic                          out_ready;
  logic [NUM_CONT*CONT_W-1:0]    opnd_a;
  logic [NUM_CONT*CONT_W-1:0]    opnd_b;
  logic [NUM_CONT*CONT_W-1:0]    opnd_c;
  logic [NUM_CONT*CONT_W-1:0]    opnd_d;
  logic [META_W-1:0]             meta_out;
  logic [(NUM_CONT+1)*ACT_LEN-1:0] action_out;
  logic [NUM_CONT-1:0]           idx_err;

  modport slave (
    input  in_valid, phv_in, action_in, out_ready,
    output in_ready, out_valid, opnd_a, opnd_b, opnd_c, opnd_d, meta_out, action_out, idx_err
  );

  modport master (
    output in_valid, phv_in, action_in, out_ready,
    input  in_ready, out_valid, opnd_a, opnd_b, opnd_c, opnd_d, meta_out, action_out, idx_err
  );
endinterface

// File: rtl/rmt_xbar_opdec.sv
// Per-container opcode decoder: maps an opcode to the A/B/C/D operand sources
// and the set of source-index fields the opcode actually reads.
module rmt_xbar_opdec
  import rmt_xbar_pkg::*;
(
  input  logic [7:0] op_i,
  output opnd_src_e  src_a_o,
  output opnd_src_e  src_b_o,
  output opnd_src_e  src_c_o,
  output opnd_src_e  src_d_o,
  output logic [2:0] idx_used_o
);

  always_comb begin
    src_a_o    = SRC_SELF;
    src_b_o    = SRC_ZERO;
    src_c_o    = SRC_SELF;
    src_d_o    = SRC_SELF;
    idx_used_o = 3'b000;
    case (op_i)
      OP_01, OP_02, OP_04, OP_06, OP_08, OP_0B, OP_12, OP_13, OP_18, OP_1C: begin
        src_a_o = SRC_PHV0; src_b_o = SRC_PHV1; idx_used_o = 3'b011;
      end
      OP_03, OP_05, OP_07, OP_09, OP_0A, OP_17, OP_1B, OP_1D: begin
        src_a_o = SRC_PHV0; src_b_o = SRC_IMM; idx_used_o = 3'b001;
      end
      OP_0E: begin
        src_a_o = SRC_ZERO; src_b_o = SRC_IMM;
      end
      OP_14: begin
        src_a_o = SRC_PHV0; src_b_o = SRC_ZERO; idx_used_o = 3'b001;
      end
      OP_10: begin
        src_a_o = SRC_PHV0; src_b_o = SRC_PHV1; src_c_o = SRC_PHV2; idx_used_o = 3'b111;
      end
      OP_11: begin
        src_a_o = SRC_PHV0; src_b_o = SRC_PHV1; src_c_o = SRC_IMM; idx_used_o = 3'b011;
      end
      OP_0C: begin
        src_a_o = SRC_PHV0; src_b_o = SRC_PHV1; src_c_o = SRC_PHV2; src_d_o = SRC_CTL;
        idx_used_o = 3'b111;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/rmt_operand_xbar.sv
// Operand crossbar for an RMT match-action stage: per-container operand muxes,
// a one-beat output register and a one-entry skid buffer behind valid/ready.
module rmt_operand_xbar
  import rmt_xbar_pkg::*;
#(
  parameter int NUM_CONT = 64,
  parameter int CONT_W   = 32,
  parameter int ACT_LEN  = 64,
  parameter int META_W   = 256,
  parameter int IDX_W    = $clog2(NUM_CONT),
  parameter int PHV_LEN  = NUM_CONT * CONT_W + META_W
) (
  input logic               clk,
  input logic               rst_n,
  rmt_operand_xbar_if.slave bus
);

  localparam int OPM    = op_msb(ACT_LEN);
  localparam int S0M    = src_msb(ACT_LEN, IDX_W, 0);
  localparam int S1M    = src_msb(ACT_LEN, IDX_W, 1);
  localparam int S2M    = src_msb(ACT_LEN, IDX_W, 2);
  localparam int CTLM   = ctl_msb(ACT_LEN, IDX_W);
  localparam int OPND_W = NUM_CONT * CONT_W;
  localparam int ACTS_W = (NUM_CONT + 1) * ACT_LEN;
  localparam int BEAT_W = 4 * OPND_W + META_W + ACTS_W + NUM_CONT;
  localparam logic [IDX_W:0] NUM_CONT_IDX = (IDX_W + 1)'(NUM_CONT);

  function automatic logic [CONT_W-1:0] pick(
    input opnd_src_e src,
    input logic [CONT_W-1:0] p0, p1, p2, imm, ctl, self_c
  );
    logic [CONT_W-1:0] r;
    case (src)
      SRC_PHV0: r = p0;
      SRC_PHV1: r = p1;
      SRC_PHV2: r = p2;
      SRC_IMM:  r = imm;
      SRC_CTL:  r = ctl;
      SRC_SELF: r = self_c;
      default:  r = '0;
    endcase
    return r;
  endfunction

  logic [CONT_W-1:0]   cont [NUM_CONT];
  logic [OPND_W-1:0]   dec_a, dec_b, dec_c, dec_d;
  logic [NUM_CONT-1:0] dec_err;

  genvar gi;
  for (gi = 0; gi < NUM_CONT; gi++) begin : g_cont
    logic [ACT_LEN-1:0] act;
    logic [IDX_W-1:0]   s0, s1, s2;
    logic [CONT_W-1:0]  p0, p1, p2, imm, ctl;
    logic [2:0]         oob, used;
    opnd_src_e          sa, sb, sc, sd;

    assign cont[gi] = bus.phv_in[PHV_LEN-1-CONT_W*(NUM_CONT-1-gi) -: CONT_W];
    // Slot 0 is stage-level, so container gi is served by slot gi+1.
    assign act = bus.action_in[(gi+1)*ACT_LEN +: ACT_LEN];
    assign s0  = act[S0M -: IDX_W];
    assign s1  = act[S1M -: IDX_W];
    assign s2  = act[S2M -: IDX_W];
    assign imm = act[CONT_W-1:0];
    assign ctl = act[CTLM -: CONT_W];

    assign oob = {({1'b0, s2} >= NUM_CONT_IDX), ({1'b0, s1} >= NUM_CONT_IDX),
                  ({1'b0, s0} >= NUM_CONT_IDX)};
    assign p0  = oob[0] ? '0 : cont[s0];
    assign p1  = oob[1] ? '0 : cont[s1];
    assign p2  = oob[2] ? '0 : cont[s2];

    rmt_xbar_opdec u_opdec (
      .op_i       (act[OPM -: 8]),
      .src_a_o    (sa),
      .src_b_o    (sb),
      .src_c_o    (sc),
      .src_d_o    (sd),
      .idx_used_o (used)
    );

    assign dec_a[gi*CONT_W +: CONT_W] = pick(sa, p0, p1, p2, imm, ctl, cont[gi]);
    assign dec_b[gi*CONT_W +: CONT_W] = pick(sb, p0, p1, p2, imm, ctl, cont[gi]);
    assign dec_c[gi*CONT_W +: CONT_W] = pick(sc, p0, p1, p2, imm, ctl, cont[gi]);
    assign dec_d[gi*CONT_W +: CONT_W] = pick(sd, p0, p1, p2, imm, ctl, cont[gi]);
    assign dec_err[gi] = |(used & oob);
  end

  logic [BEAT_W-1:0] beat_in, out_q, out_d, skid_q, skid_d;
  logic              out_valid_q, out_valid_d, skid_valid_q, skid_valid_d, in_ready_q;
  logic              accept, out_load;

  assign beat_in  = {dec_a, dec_b, dec_c, dec_d, bus.phv_in[META_W-1:0], bus.action_in, dec_err};
  assign accept   = bus.in_valid && in_ready_q;
  assign out_load = !out_valid_q || bus.out_ready;

  // A parked skid beat always refills the output first; in_ready is low then,
  // so no new beat can compete for the slot.
  always_comb begin
    out_d        = out_q;
    out_valid_d  = out_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    if (out_load) begin
      if (skid_valid_q) begin
        out_d        = skid_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else begin
        out_valid_d = accept;
        if (accept) out_d = beat_in;
      end
    end else if (accept) begin
      skid_d       = beat_in;
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q        <= '0;
      out_valid_q  <= 1'b0;
      skid_q       <= '0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
    end else begin
      out_q        <= out_d;
      out_valid_q  <= out_valid_d;
      skid_q       <= skid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= !skid_valid_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign {bus.opnd_a, bus.opnd_b, bus.opnd_c, bus.opnd_d,
          bus.meta_out, bus.action_out, bus.idx_err} = out_q;

endmodule

// File: tb/tb_rmt_operand_xbar.sv
// Directed bench for rmt_operand_xbar with 48 containers, so that source
// indices past the container count can be exercised.
module tb_rmt_operand_xbar;

  localparam int NC = 48;
  localparam int CW = 32;
  localparam int AL = 64;
  localparam int MW = 256;
  localparam int AW = (NC + 1) * AL;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rmt_operand_xbar_if #(.NUM_CONT(NC), .CONT_W(CW), .ACT_LEN(AL), .META_W(MW)) bus ();

  rmt_operand_xbar #(.NUM_CONT(NC), .CONT_W(CW), .ACT_LEN(AL), .META_W(MW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] get_a(input int i); return bus.opnd_a[i*CW +: CW]; endfunction
  function automatic logic [31:0] get_b(input int i); return bus.opnd_b[i*CW +: CW]; endfunction
  function automatic logic [31:0] get_c(input int i); return bus.opnd_c[i*CW +: CW]; endfunction
  function automatic logic [31:0] get_d(input int i); return bus.opnd_d[i*CW +: CW]; endfunction

  function automatic logic [63:0] mk_act(input logic [7:0] op, input logic [5:0] s0, s1, s2,
                                         input logic [31:0] imm);
    return {op, s0, s1, s2, 6'h00, imm};
  endfunction

  function automatic logic [63:0] mk_ctl(input logic [7:0] op, input logic [5:0] s0, s1,
                                         input logic [31:0] ctl);
    return {op, s0, s1, ctl, 12'h000};
  endfunction

  task automatic set_cont(input int i, input logic [31:0] v);
    bus.phv_in[MW + i*CW +: CW] = v;
  endtask

  task automatic set_slot(input int k, input logic [63:0] w);
    bus.action_in[k*AL +: AL] = w;
  endtask

  // Container j holds C000_00jj, metadata carries the tag, all actions op 00.
  task automatic base_beat(input logic [31:0] tag);
    for (int j = 0; j < NC; j++) set_cont(j, 32'hC000_0000 + j);
    bus.phv_in[MW-1:0] = {224'h0, tag};
    bus.action_in = '0;
  endtask

  task automatic run_beat();
    @(negedge clk);
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
    checks++; if (bus.opnd_a !== '0) begin errors++; $display("FAIL reset_opnd_a got nonzero want 0"); end
    checks++; if (bus.action_out !== '0) begin errors++; $display("FAIL reset_action_out got nonzero want 0"); end
    checks++; if (bus.idx_err !== '0) begin errors++; $display("FAIL reset_idx_err got %h want 0", bus.idx_err); end
    rst_n = 1'b1;
  endtask

  task automatic test_two_source();
    base_beat(32'h1);
    set_cont(5, 32'h11);
    set_cont(7, 32'h22);
    set_slot(4, mk_act(8'h01, 6'd5, 6'd7, 6'd0, 32'h0));
    run_beat();
    $display("beat two_source out_valid=%b", bus.out_valid);
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL two_src_latency got %b want 1", bus.out_valid); end
    checks++; if (get_a(3) !== 32'h11) begin errors++; $display("FAIL two_src_a3 got %h want 00000011", get_a(3)); end
    checks++; if (get_b(3) !== 32'h22) begin errors++; $display("FAIL two_src_b3 got %h want 00000022", get_b(3)); end
    checks++; if (get_c(3) !== 32'hC000_0003) begin errors++; $display("FAIL two_src_c3 got %h want c0000003", get_c(3)); end
    checks++; if (get_d(3) !== 32'hC000_0003) begin errors++; $display("FAIL two_src_d3 got %h want c0000003", get_d(3)); end
    checks++; if (bus.idx_err !== '0) begin errors++; $display("FAIL two_src_err got %h want 0", bus.idx_err); end
    checks++; if (bus.meta_out !== {224'h0, 32'h1}) begin errors++; $display("FAIL two_src_meta got %h want 1", bus.meta_out[31:0]); end
  endtask

  task automatic test_imm_default();
    base_beat(32'h2);
    set_slot(1, mk_act(8'h0E, 6'd0, 6'd0, 6'd0, 32'hDEAD_BEEF));
    run_beat();
    $display("beat imm_default out_valid=%b", bus.out_valid);
    checks++; if (get_a(0) !== 32'h0) begin errors++; $display("FAIL imm_a0 got %h want 0", get_a(0)); end
    checks++; if (get_b(0) !== 32'hDEAD_BEEF) begin errors++; $display("FAIL imm_b0 got %h want deadbeef", get_b(0)); end
    checks++; if (get_c(0) !== 32'hC000_0000) begin errors++; $display("FAIL imm_c0 got %h want c0000000", get_c(0)); end
    checks++; if (get_a(1) !== 32'hC000_0001) begin errors++; $display("FAIL dflt_a1 got %h want c0000001", get_a(1)); end
    checks++; if (get_b(1) !== 32'h0) begin errors++; $display("FAIL dflt_b1 got %h want 0", get_b(1)); end
    checks++; if (get_d(1) !== 32'hC000_0001) begin errors++; $display("FAIL dflt_d1 got %h want c0000001", get_d(1)); end
  endtask

  // ctl = 12ABCDE0 puts 6'd4 into the s2 bits it shares.
  task automatic test_ctl();
    base_beat(32'h3);
    set_slot(3, mk_ctl(8'h0C, 6'd1, 6'd2, 32'h12AB_CDE0));
    run_beat();
    $display("beat ctl out_valid=%b", bus.out_valid);
    checks++; if (get_a(2) !== 32'hC000_0001) begin errors++; $display("FAIL ctl_a2 got %h want c0000001", get_a(2)); end
    checks++; if (get_b(2) !== 32'hC000_0002) begin errors++; $display("FAIL ctl_b2 got %h want c0000002", get_b(2)); end
    checks++; if (get_c(2) !== 32'hC000_0004) begin errors++; $display("FAIL ctl_c2 got %h want c0000004", get_c(2)); end
    checks++; if (get_d(2) !== 32'h12AB_CDE0) begin errors++; $display("FAIL ctl_d2 got %h want 12abcde0", get_d(2)); end
    checks++; if (bus.idx_err !== '0) begin errors++; $display("FAIL ctl_err got %h want 0", bus.idx_err); end
  endtask

  task automatic test_idx_err();
    base_beat(32'h4);
    set_slot(6, mk_act(8'h01, 6'd2, 6'd50, 6'd0, 32'h0));
    set_slot(7, mk_act(8'h09, 6'd3, 6'd63, 6'd0, 32'h55));
    set_slot(8, mk_act(8'h10, 6'd0, 6'd1, 6'd47, 32'h0));
    set_slot(9, mk_act(8'h10, 6'd0, 6'd1, 6'd48, 32'h0));
    run_beat();
    $display("beat idx_err out_valid=%b err=%h", bus.out_valid, bus.idx_err);
    checks++; if (get_a(5) !== 32'hC000_0002) begin errors++; $display("FAIL oob_a5 got %h want c0000002", get_a(5)); end
    checks++; if (get_b(5) !== 32'h0) begin errors++; $display("FAIL oob_b5 got %h want 0", get_b(5)); end
    checks++; if (get_a(6) !== 32'hC000_0003) begin errors++; $display("FAIL unused_a6 got %h want c0000003", get_a(6)); end
    checks++; if (get_b(6) !== 32'h55) begin errors++; $display("FAIL unused_b6 got %h want 55", get_b(6)); end
    checks++; if (get_c(7) !== 32'hC000_002F) begin errors++; $display("FAIL edge47_c7 got %h want c000002f", get_c(7)); end
    checks++; if (get_c(8) !== 32'h0) begin errors++; $display("FAIL edge48_c8 got %h want 0", get_c(8)); end
    checks++; if (bus.idx_err !== 48'h0000_0000_0120) begin errors++; $display("FAIL oob_mask got %h want 000000000120", bus.idx_err); end
  endtask

  task automatic test_back_to_back();
    int sent, got, inflight;
    logic acc, con;
    logic [AW-1:0] exp_act;
    sent = 0; got = 0; inflight = 0;
    for (int c = 0; c < 80 && got < 10; c++) begin
      @(negedge clk);
      checks++; if (bus.in_ready !== (inflight < 2)) begin errors++; $display("FAIL b2b_in_ready cyc %0d got %b want %b", c, bus.in_ready, (inflight < 2)); end
      checks++; if (bus.out_valid !== (inflight > 0)) begin errors++; $display("FAIL b2b_out_valid cyc %0d got %b want %b", c, bus.out_valid, (inflight > 0)); end
      if (bus.out_valid === 1'b1) begin
        exp_act = '0;
        exp_act[63:0] = 64'hF000_0000_0000_0000 + 64'(got);
        checks++; if (bus.meta_out !== {224'h0, 32'hA000_0000 + 32'(got)}) begin errors++; $display("FAIL b2b_meta cyc %0d got %h want %h", c, bus.meta_out[31:0], 32'hA000_0000 + 32'(got)); end
        checks++; if (get_a(0) !== 32'hB000_0000 + 32'(got)) begin errors++; $display("FAIL b2b_a0 cyc %0d got %h want %h", c, get_a(0), 32'hB000_0000 + 32'(got)); end
        checks++; if (bus.action_out !== exp_act) begin errors++; $display("FAIL b2b_action cyc %0d got %h want %h", c, bus.action_out[63:0], exp_act[63:0]); end
      end
      bus.out_ready = (c % 4 == 0) || (c % 4 == 3);
      if (sent < 10) begin
        base_beat(32'hA000_0000 + 32'(sent));
        set_cont(0, 32'hB000_0000 + 32'(sent));
        set_slot(0, 64'hF000_0000_0000_0000 + 64'(sent));
        bus.in_valid = 1'b1;
      end else begin
        bus.in_valid = 1'b0;
      end
      acc = bus.in_valid && bus.in_ready;
      con = bus.out_valid && bus.out_ready;
      if (con) $display("beat b2b %0d leaves meta=%h", got, bus.meta_out[31:0]);
      if (acc) sent++;
      if (con) got++;
      inflight = inflight + int'(acc) - int'(con);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    checks++; if (got !== 10) begin errors++; $display("FAIL b2b_count got %0d want 10", got); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL b2b_no_dup got %b want 0", bus.out_valid); end
  endtask

  task automatic test_mid_reset();
    @(negedge clk);
    bus.out_ready = 1'b0;
    base_beat(32'h51);
    bus.in_valid = 1'b1;
    @(negedge clk);
    base_beat(32'h52);
    @(negedge clk);
    bus.in_valid = 1'b0;
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL mrst_full got %b want 0", bus.in_ready); end
    rst_n = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL mrst_out_valid got %b want 0", bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL mrst_in_ready got %b want 1", bus.in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    base_beat(32'h53);
    run_beat();
    $display("beat after_reset meta=%h", bus.meta_out[31:0]);
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL mrst_next_valid got %b want 1", bus.out_valid); end
    checks++; if (bus.meta_out !== {224'h0, 32'h53}) begin errors++; $display("FAIL mrst_next_meta got %h want 53", bus.meta_out[31:0]); end
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL mrst_no_stale got %b want 0", bus.out_valid); end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.phv_in    = '0;
    bus.action_in = '0;
    test_reset();
    test_two_source();
    test_imm_default();
    test_ctl();
    test_idx_err();
    test_back_to_back();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
